// File: rtl/fsic_io_serdes_tx.sv
// fsic_io_serdes_tx: single-lane transmit serializer for the FSIC io_serdes link.
// Parallel words enter a small FIFO through a valid/ready handshake and are shifted
// out LSB-first, one bit per ioclk, aligned to a free-running word-phase counter.
// Optional build macro FSIC_TX_UNDERFLOW_CNT_EN adds a saturating 8-bit count of
// word loads taken from an empty FIFO (port underflow_cnt).
module fsic_io_serdes_tx #(
    parameter int pCLK_RATIO    = 4,
    parameter int pTxFIFO_DEPTH = 4
) (
    input  logic                             ioclk,
    input  logic                             axis_rst,
    input  logic                             txen,
    input  logic [pCLK_RATIO-1:0]            txdata_in,
    input  logic                             txdata_valid,
    output logic                             txdata_ready,
    output logic                             serial_data_out,
    output logic                             txclk_en,
    output logic [$clog2(pCLK_RATIO)-1:0]    phase_out,
    output logic [$clog2(pTxFIFO_DEPTH):0]   fifo_level
`ifdef FSIC_TX_UNDERFLOW_CNT_EN
    ,
    output logic [7:0]                       underflow_cnt
`endif
);

    localparam int PW = $clog2(pCLK_RATIO);
    localparam int AW = $clog2(pTxFIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [PW-1:0] LAST_PHASE = PW'(pCLK_RATIO - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(pTxFIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_t;

    state_t                  state;
    logic [PW-1:0]           phase;
    logic [pCLK_RATIO-1:0]   shift_reg;

    logic [pCLK_RATIO-1:0]   mem [pTxFIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [LW-1:0]           count;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    boundary;
    logic [pCLK_RATIO-1:0]   load_word;

    // Handshake, word-boundary detect and the word to load at that boundary.
    // Every state moves to RUN exactly when txen is high, so the boundary is
    // simply the last phase with txen sampled high (IDLE parks on the last phase).
    always_comb begin
        fifo_full  = (count == FULL_LEVEL);
        fifo_empty = (count == '0);
        push       = txdata_valid && !fifo_full;
        boundary   = (phase == LAST_PHASE) && txen;
        pop        = boundary && !fifo_empty;
        load_word  = fifo_empty ? '0 : mem[rd_ptr];
    end

    // Lane FSM: state, bit phase, shift register and registered clock enable.
    always_ff @(posedge ioclk or posedge axis_rst) begin
        if (axis_rst) begin
            state     <= StIdle;
            phase     <= LAST_PHASE;
            shift_reg <= '0;
            txclk_en  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (txen) begin
                        state    <= StRun;
                        phase    <= '0;
                        txclk_en <= 1'b1;
                    end
                end
                StRun, StDrain: begin
                    if (txen) begin
                        state <= StRun;
                        phase <= phase + PW'(1);
                    end else if (phase == LAST_PHASE) begin
                        // Word finished with the lane disabled: park without loading.
                        state    <= StIdle;
                        phase    <= LAST_PHASE;
                        txclk_en <= 1'b0;
                    end else begin
                        state <= StDrain;
                        phase <= phase + PW'(1);
                    end
                end
                default: begin
                    state    <= StIdle;
                    phase    <= LAST_PHASE;
                    txclk_en <= 1'b0;
                end
            endcase
            if (boundary) begin
                shift_reg <= load_word;
            end
        end
    end

    // FIFO storage; contents are don't-care while not occupied, so no reset.
    always_ff @(posedge ioclk) begin
        if (push) begin
            mem[wr_ptr] <= txdata_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge ioclk or posedge axis_rst) begin
        if (axis_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FSIC_TX_UNDERFLOW_CNT_EN
    // Saturating count of boundary loads that found the FIFO empty.
    always_ff @(posedge ioclk or posedge axis_rst) begin
        if (axis_rst) begin
            underflow_cnt <= 8'h00;
        end else if (boundary && fifo_empty && (underflow_cnt != 8'hFF)) begin
            underflow_cnt <= underflow_cnt + 8'h01;
        end
    end
`endif

    // Output decode straight from registers; phase 0 carries bit 0.
    always_comb begin
        txdata_ready    = !fifo_full;
        fifo_level      = count;
        phase_out       = phase;
        serial_data_out = shift_reg[phase] & txclk_en;
    end

endmodule

// File: tb/tb_fsic_io_serdes_tx.sv
// Self-checking bench for fsic_io_serdes_tx: directed scenarios plus a randomized
// run, all compared every cycle against a word-level reference model.
module tb_fsic_io_serdes_tx;

    localparam int R = 4;
    localparam int D = 4;

    logic         ioclk = 1'b0;
    logic         axis_rst = 1'b1;
    logic         txen = 1'b0;
    logic [R-1:0] txdata_in = '0;
    logic         txdata_valid = 1'b0;
    logic         txdata_ready;
    logic         serial_data_out;
    logic         txclk_en;
    logic [1:0]   phase_out;
    logic [2:0]   fifo_level;
`ifdef FSIC_TX_UNDERFLOW_CNT_EN
    logic [7:0]   underflow_cnt;
`endif

    fsic_io_serdes_tx #(
        .pCLK_RATIO   (R),
        .pTxFIFO_DEPTH(D)
    ) dut (
        .ioclk          (ioclk),
        .axis_rst       (axis_rst),
        .txen           (txen),
        .txdata_in      (txdata_in),
        .txdata_valid   (txdata_valid),
        .txdata_ready   (txdata_ready),
        .serial_data_out(serial_data_out),
        .txclk_en       (txclk_en),
        .phase_out      (phase_out),
        .fifo_level     (fifo_level)
`ifdef FSIC_TX_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt  (underflow_cnt)
`endif
    );

    always #5 ioclk = ~ioclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: lane on/off, position within the current word, the word
    // being sent, the queued words, and the number of empty-FIFO loads.
    bit           m_on;
    int           m_pos;
    logic [R-1:0] m_cur;
    logic [R-1:0] m_q[$];
    int           m_uf;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on  = 1'b0;
        m_pos = R - 1;
        m_cur = '0;
        m_q.delete();
        m_uf  = 0;
    endtask

    task automatic model_load();
        if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
        end else begin
            m_cur = '0;
            m_uf++;
        end
    endtask

    // A running lane always finishes its word; whether the next word starts
    // depends only on txen at the word's end.
    task automatic model_edge(input bit en, input bit v, input logic [R-1:0] d);
        bit can_push;
        can_push = (m_q.size() < D);
        if (!m_on) begin
            if (en) begin
                m_on = 1'b1;
                model_load();
                m_pos = 0;
            end
        end else if (m_pos == R - 1) begin
            if (en) begin
                model_load();
                m_pos = 0;
            end else begin
                m_on = 1'b0;
            end
        end else begin
            m_pos++;
        end
        if (v && can_push) m_q.push_back(d);
    endtask

    task automatic check_outputs();
        logic exp_bit;
        exp_bit = m_on ? m_cur[m_pos] : 1'b0;
        check_val("txclk_en", txclk_en, m_on);
        check_val("phase_out", phase_out, m_pos);
        check_val("serial_data_out", serial_data_out, exp_bit);
        check_val("txdata_ready", txdata_ready, m_q.size() < D);
        check_val("fifo_level", fifo_level, m_q.size());
`ifdef FSIC_TX_UNDERFLOW_CNT_EN
        check_val("underflow_cnt", underflow_cnt, (m_uf > 255) ? 255 : m_uf);
`endif
    endtask

    // One ioclk cycle: drive, sample on the falling edge, advance the model.
    task automatic step(input bit en, input bit v, input logic [R-1:0] d);
        txen         = en;
        txdata_valid = v;
        txdata_in    = d;
        @(negedge ioclk);
        check_outputs();
        model_edge(en, v, d);
        @(posedge ioclk);
        #1;
    endtask

    task automatic do_reset();
        axis_rst     = 1'b1;
        txen         = 1'b0;
        txdata_valid = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge ioclk);
            check_outputs();
        end
        axis_rst = 1'b0;
        @(posedge ioclk);
        #1;
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        txen         = 1'b0;
        txdata_valid = 1'b0;
        axis_rst     = 1'b1;
        #1;
        model_reset();
        check_val("arst_sdo", serial_data_out, 1'b0);
        check_val("arst_level", fifo_level, 0);
        check_val("arst_txclk_en", txclk_en, 1'b0);
        check_val("arst_phase", phase_out, R - 1);
        check_val("arst_ready", txdata_ready, 1'b1);
`ifdef FSIC_TX_UNDERFLOW_CNT_EN
        check_val("arst_uf_cnt", underflow_cnt, 0);
`endif
        @(negedge ioclk);
        axis_rst = 1'b0;
        @(posedge ioclk);
        #1;
    endtask

    initial begin
        bit en;
        int vprob;

        // Reset then idle.
        model_reset();
        #2;
        do_reset();
        repeat (10) step(1'b0, 1'b0, '0);

        // Single word pushed in IDLE, then enable; zeros follow on underflow.
        step(1'b0, 1'b1, 4'b1011);
        repeat (12) step(1'b1, 1'b0, '0);
        repeat (6) step(1'b0, 1'b0, '0);

        // Back-to-back stream.
        step(1'b1, 1'b1, 4'hA);
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b1, 4'hF);
        step(1'b1, 1'b1, 4'h0);
        repeat (20) step(1'b1, 1'b0, '0);
        repeat (6) step(1'b0, 1'b0, '0);

        // FIFO full with valid held; fifth word waits for the first pop.
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, R'(i));
        repeat (4) step(1'b0, 1'b1, 4'h5);
        repeat (8) step(1'b1, 1'b1, 4'h5);
        repeat (24) step(1'b1, 1'b0, '0);
        repeat (6) step(1'b0, 1'b0, '0);

        // Mid-word disable at phase 1, with a word left queued.
        step(1'b0, 1'b1, 4'h6);
        step(1'b0, 1'b1, 4'h9);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        repeat (8) step(1'b0, 1'b0, '0);

        // Disable sampled exactly at a word end, and re-enable during drain.
        step(1'b1, 1'b1, 4'hC);
        repeat (3) step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 4'h3);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        repeat (6) step(1'b1, 1'b0, '0);
        repeat (6) step(1'b0, 1'b0, '0);

        // Randomized traffic.
        en = 1'b0;
        for (int blk = 0; blk < 6; blk++) begin
            vprob = 1 + blk % 3;
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 15) == 0) en = ~en;
                step(en, $urandom_range(0, 3) < vprob, R'($urandom));
            end
        end

        // Asynchronous reset at phase 2 with three words queued.
        repeat (6) step(1'b0, 1'b0, '0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, R'(4'h8 + i));
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check_val("pre_arst_phase", phase_out, 2);
        check_val("pre_arst_level", fifo_level, 3);
        async_reset();
        repeat (4) step(1'b0, 1'b0, '0);

`ifdef FSIC_TX_UNDERFLOW_CNT_EN
        // Underflow counter: five loads, reset clears it, then saturation.
        repeat (20) step(1'b1, 1'b0, '0);
        check_val("uf_cnt_five", underflow_cnt, 5);
        async_reset();
        repeat (300 * R + 8) step(1'b1, 1'b0, '0);
        check_val("uf_cnt_sat", underflow_cnt, 8'hFF);
        repeat (4) step(1'b0, 1'b0, '0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, limit %0d", 2000000);
        $fatal(1);
    end

endmodule
